// File: rtl/display_pkg.sv
// Shared types and active-low segment patterns ({g,f,e,d,c,b,a}) for the display scanner.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/display_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed common-anode 7-segment scanner stepped by a divider tap.
// Optional macro DISPLAY_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
//   state | meaning
//   IDLE  | after reset, outputs off, waiting for first tick
//   BLANK | all anodes off while the counter runs down
//   SHOW  | digit idx driven until the next tick
module display_scanner #(
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  scan_tap,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     anode_n,
  output logic [6:0]            segment_n,
  output logic                  dp_n
);
  import display_pkg::*;

  localparam int IW = $clog2(DIGITS);
  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IW-1:0] LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] RELOAD = CW'(BLANK_CYCLES - 1);

  logic s1, s2, s3, tick;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic capture;
  logic [DIGITS-1:0][3:0] shadow;
  logic [DIGITS-1:0] shadow_dp;
  logic [6:0] seg_dec;
  logic lz_blank;

  assign tick = s2 & ~s3;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan_tap;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    capture = 1'b0;
    if (tick) begin
      state_d = BLANK;
      cnt_d   = RELOAD;
      idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
      capture = (idx_q == LAST);
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == '0) state_d = SHOW;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  hex_to_7seg u_dec (
    .nibble(shadow[idx_q]),
    .seg   (seg_dec)
  );

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  logic upper_zero;
  // Digit i is blank when it and every more-significant nibble are zero; digit 0 never is.
  always_comb begin
    lz_blank   = 1'b0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (shadow[i] == 4'h0);
      if (idx_q == IW'(i)) lz_blank = upper_zero;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= LAST;
      shadow    <= '0;
      shadow_dp <= '0;
      anode_n   <= '1;
      segment_n <= SEG_OFF;
      dp_n      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (capture) begin
        shadow    <= value_in;
        shadow_dp <= dp_in;
      end
      // Outputs follow the next state so SHOW is visible on the edge it is entered.
      if (state_d == SHOW) begin
        anode_n   <= ~(DIGITS'(1) << idx_q);
        segment_n <= lz_blank ? SEG_OFF : seg_dec;
        dp_n      <= ~shadow_dp[idx_q];
      end else begin
        anode_n   <= '1;
        segment_n <= SEG_OFF;
        dp_n      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with a per-cycle behavioural model.
module tb_display_scanner;

  localparam int DIGITS = 4;
  localparam int BC     = 4;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b0;
  logic        scan_tap = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  dp_in    = 4'h0;
  logic [3:0]  anode_n;
  logic [6:0]  segment_n;
  logic        dp_n;

  int n_cmp = 0;
  int n_bad = 0;

  display_scanner #(.DIGITS(DIGITS), .BLANK_CYCLES(BC)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .scan_tap (scan_tap),
    .value_in (value_in),
    .dp_in    (dp_in),
    .anode_n  (anode_n),
    .segment_n(segment_n),
    .dp_n     (dp_n)
  );

  always #5 clock_in = ~clock_in;

  // Segment patterns, {g,f,e,d,c,b,a} active-low, for 0..F.
  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] LZ_OR_ZERO =
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    7'h7F;
`else
    7'b1000000;
`endif

  // Model: a tap rise sampled at edge E takes effect at E+2; digit shown BC edges later.
  int         m_digit;
  logic [15:0] m_shadow;
  logic [3:0]  m_sdp;
  bit         m_active, m_prev, m_r1, m_r2, eff;
  int         m_since;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  function automatic logic [6:0] model_seg(int d, logic [15:0] sh);
    logic [3:0] nib;
    nib = sh[4*d +: 4];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (d != 0 && (sh >> (4*d)) == 16'h0) return 7'h7F;
`endif
    return hex_tab[nib];
  endfunction

  always @(posedge clock_in) begin
    if (!reset_n) begin
      m_digit = DIGITS - 1; m_shadow = '0; m_sdp = '0;
      m_active = 0; m_since = 0; m_prev = 0; m_r1 = 0; m_r2 = 0;
    end else begin
      eff  = m_r2;
      m_r2 = m_r1;
      m_r1 = scan_tap && !m_prev;
      m_prev = scan_tap;
      if (eff) begin
        m_digit = (m_digit + 1) % DIGITS;
        if (m_digit == 0) begin
          m_shadow = value_in;
          m_sdp    = dp_in;
        end
        m_since  = 0;
        m_active = 1;
      end else if (m_since < 1000000) begin
        m_since++;
      end
    end
    #1;
    if (m_active && m_since >= BC) begin
      e_an  = ~(4'b0001 << m_digit);
      e_seg = model_seg(m_digit, m_shadow);
      e_dp  = ~m_sdp[m_digit];
    end else begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end
    n_cmp++;
    if (anode_n !== e_an || segment_n !== e_seg || dp_n !== e_dp) begin
      n_bad++;
      $display("FAIL model t=%0t: got anode=%b seg=%b dp=%b, want anode=%b seg=%b dp=%b",
               $time, anode_n, segment_n, dp_n, e_an, e_seg, e_dp);
    end
  end

  task automatic check_lit(string name, logic [3:0] ea, logic [6:0] es, logic ed);
    n_cmp++;
    if (anode_n !== ea || segment_n !== es || dp_n !== ed) begin
      n_bad++;
      $display("FAIL %s: got anode=%b seg=%b dp=%b, want anode=%b seg=%b dp=%b",
               name, anode_n, segment_n, dp_n, ea, es, ed);
    end
  endtask

  task automatic show_step(string name, logic [3:0] ea, logic [6:0] es, logic ed);
    @(negedge clock_in) scan_tap = 1'b1;
    @(posedge clock_in);
    repeat (5) @(posedge clock_in);
    #1 check_lit({name, "_blank"}, 4'hF, 7'h7F, 1'b1);
    @(posedge clock_in);
    #1 check_lit(name, ea, es, ed);
    @(negedge clock_in) scan_tap = 1'b0;
    repeat (8) @(negedge clock_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock_in) scan_tap = ~scan_tap;
    check_lit("reset", 4'hF, 7'h7F, 1'b1);
    @(negedge clock_in) begin scan_tap = 1'b0; reset_n = 1'b1; end
    repeat (10) @(negedge clock_in);
    check_lit("idle", 4'hF, 7'h7F, 1'b1);

    value_in = 16'h1A80; dp_in = 4'b0100;
    show_step("scan_d0", 4'b1110, 7'b1000000, 1'b1);
    show_step("scan_d1", 4'b1101, 7'b0000000, 1'b1);
    show_step("scan_d2", 4'b1011, 7'b0001000, 1'b0);
    show_step("scan_d3", 4'b0111, 7'b1111001, 1'b1);

    value_in = 16'h1111; dp_in = 4'b0000;
    show_step("tear_d0", 4'b1110, 7'b1111001, 1'b1);
    show_step("tear_d1", 4'b1101, 7'b1111001, 1'b1);
    value_in = 16'h2222;
    show_step("tear_d2", 4'b1011, 7'b1111001, 1'b1);
    show_step("tear_d3", 4'b0111, 7'b1111001, 1'b1);
    show_step("tear_d0new", 4'b1110, 7'b0100100, 1'b1);

    @(negedge clock_in) scan_tap = 1'b1;
    repeat (1000) @(negedge clock_in);
    check_lit("held_d1", 4'b1101, 7'b0100100, 1'b1);
    scan_tap = 1'b0;
    repeat (8) @(negedge clock_in);
    show_step("after_held", 4'b1011, 7'b0100100, 1'b1);

    value_in = 16'h4321; dp_in = 4'b0001;
    @(negedge clock_in) reset_n = 1'b0;
    @(posedge clock_in);
    #1 check_lit("midrst_off", 4'hF, 7'h7F, 1'b1);
    @(negedge clock_in) reset_n = 1'b1;
    repeat (5) @(negedge clock_in);
    show_step("midrst_d0", 4'b1110, 7'b1111001, 1'b0);
    show_step("midrst_d1", 4'b1101, 7'b0100100, 1'b1);

    value_in = 16'h0005; dp_in = 4'b0000;
    show_step("lz_old_d2", 4'b1011, 7'b0110000, 1'b1);
    show_step("lz_old_d3", 4'b0111, 7'b0011001, 1'b1);
    show_step("lz_d0", 4'b1110, 7'b0010010, 1'b1);
    show_step("lz_d1", 4'b1101, LZ_OR_ZERO, 1'b1);
    show_step("lz_d2", 4'b1011, LZ_OR_ZERO, 1'b1);
    show_step("lz_d3", 4'b0111, LZ_OR_ZERO, 1'b1);

    repeat (4) @(negedge clock_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
